// File: rtl/i2c_passthru_bitrx.sv
// Receive side of the passthru bit bridge: slices each local SCL period into a
// bit descriptor for the far-side transmitter and stretches SCL until it catches up.
module i2c_passthru_bitrx #(
  parameter int F_REF_T_SU_DAT       = 2,
  parameter int F_REF_T_LOW          = 38,
  parameter int WIDTH_F_REF_T_SU_DAT = 2,
  parameter int WIDTH_F_REF_T_LOW    = 6
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_start_rx,
  input  logic i_release_scl,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda_init_valid,
  output logic o_sda_init,
  output logic o_sda_mid_change,
  output logic o_sda_final,
  output logic o_rx_done,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_violation
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCL0_HOLD,
    ST_SCL0_REL,
    ST_SCL1,
    ST_VIOLATION
  } state_t;

  typedef struct packed {
    logic init_valid;
    logic init;
    logic mid_change;
    logic fin;
    logic start_det;
    logic stop_det;
  } desc_t;

  localparam desc_t DESC_RST = '{init_valid: 1'b0, init: 1'b1, mid_change: 1'b0,
                                 fin: 1'b1, start_det: 1'b0, stop_det: 1'b0};
  localparam logic [WIDTH_F_REF_T_LOW-1:0]    T_LOW_LOAD = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
  localparam logic [WIDTH_F_REF_T_SU_DAT-1:0] T_SU_LOAD  = WIDTH_F_REF_T_SU_DAT'(F_REF_T_SU_DAT);

  state_t state, state_nxt;
  desc_t  desc;

  logic prev_f_ref, prev_sda;
  logic pulse_ref, sda_chg;
  logic [WIDTH_F_REF_T_LOW-1:0]    t_low_cnt, t_free_cnt;
  logic [WIDTH_F_REF_T_SU_DAT-1:0] t_su_cnt;
  logic t_low_tc, t_su_tc, t_free_tc;
  logic hold_valid, stop_hold, bus_free;

  assign pulse_ref  = i_f_ref & ~prev_f_ref;
  assign sda_chg    = i_sda ^ prev_sda;
  assign t_low_tc   = (t_low_cnt == '0);
  assign t_su_tc    = (t_su_cnt == '0);
  assign t_free_tc  = (t_free_cnt == '0);
  assign hold_valid = t_low_tc & t_su_tc;
  // Bus-free wait after a STOP: SCL high, SDA high and quiet since the STOP edge.
  assign stop_hold  = (state == ST_SCL1) & desc.mid_change & i_scl & i_sda & ~sda_chg;
  assign bus_free   = stop_hold & t_free_tc;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      prev_f_ref <= 1'b0;
      prev_sda   <= 1'b1;
    end else begin
      prev_f_ref <= i_f_ref;
      prev_sda   <= i_sda;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_scl || state == ST_IDLE)
      t_low_cnt <= T_LOW_LOAD;
    else if (pulse_ref && !t_low_tc)
      t_low_cnt <= t_low_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || sda_chg)
      t_su_cnt <= T_SU_LOAD;
    else if (pulse_ref && !t_su_tc)
      t_su_cnt <= t_su_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || !stop_hold)
      t_free_cnt <= T_LOW_LOAD;
    else if (pulse_ref && !t_free_tc)
      t_free_cnt <= t_free_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (i_start_rx) state_nxt = i_scl ? ST_SCL1 : ST_SCL0_HOLD;
      ST_SCL0_HOLD:
        if (hold_valid && i_release_scl) state_nxt = ST_SCL0_REL;
      ST_SCL0_REL:
        if (sda_chg)    state_nxt = ST_VIOLATION;
        else if (i_scl) state_nxt = ST_SCL1;
      ST_SCL1:
        // An SCL fall wins over a coincident SDA move (hold-time slop).
        if (!i_scl)                         state_nxt = ST_IDLE;
        else if (sda_chg && desc.mid_change) state_nxt = ST_VIOLATION;
        else if (bus_free)                   state_nxt = ST_IDLE;
      ST_VIOLATION:
        state_nxt = ST_VIOLATION;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_scl            = (state != ST_SCL0_HOLD);
    o_sda_init_valid = (state == ST_SCL0_HOLD) ? hold_valid : desc.init_valid;
    o_rx_done        = (state == ST_IDLE);
    o_violation      = (state == ST_VIOLATION);
    o_sda_init       = desc.init;
    o_sda_mid_change = desc.mid_change;
    o_sda_final      = desc.fin;
    o_start_det      = desc.start_det;
    o_stop_det       = desc.stop_det;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      desc <= DESC_RST;
    end else begin
      desc.start_det <= 1'b0;
      desc.stop_det  <= 1'b0;
      case (state)
        ST_IDLE:
          if (i_start_rx) begin
            desc.mid_change <= 1'b0;
            desc.init_valid <= i_scl;
            if (i_scl) desc.init <= i_sda;
          end
        ST_SCL0_HOLD: begin
          desc.init <= i_sda;
          if (hold_valid && i_release_scl) desc.init_valid <= 1'b1;
        end
        ST_SCL1:
          if (!i_scl) begin
            desc.fin <= prev_sda;
          end else if (sda_chg && !desc.mid_change) begin
            desc.mid_change <= 1'b1;
            desc.start_det  <= ~i_sda;
            desc.stop_det   <= i_sda;
          end else if (bus_free) begin
            desc.fin <= 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// Directed bench for i2c_passthru_bitrx: data bit, stretch, START/STOP, violations.
module tb_i2c_passthru_bitrx;

  logic i_clk = 1'b0;
  logic i_rstn, i_f_ref, i_start_rx, i_release_scl, i_sda, scl_m;
  logic i_scl;
  logic o_scl, o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final;
  logic o_rx_done, o_start_det, o_stop_det, o_violation;

  int total = 0;
  int passed = 0;

  localparam logic [8:0] RST_VEC = 9'b1_0_1_0_1_1_0_0_0;

  // Wired-AND bus: the master side and the DUT both can hold SCL low.
  assign i_scl = scl_m & o_scl;

  i2c_passthru_bitrx #(
    .F_REF_T_SU_DAT(2), .F_REF_T_LOW(4),
    .WIDTH_F_REF_T_SU_DAT(2), .WIDTH_F_REF_T_LOW(3)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_f_ref(i_f_ref), .i_start_rx(i_start_rx),
    .i_release_scl(i_release_scl), .i_scl(i_scl), .i_sda(i_sda),
    .o_scl(o_scl), .o_sda_init_valid(o_sda_init_valid), .o_sda_init(o_sda_init),
    .o_sda_mid_change(o_sda_mid_change), .o_sda_final(o_sda_final),
    .o_rx_done(o_rx_done), .o_start_det(o_start_det), .o_stop_det(o_stop_det),
    .o_violation(o_violation)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    i_f_ref = 1'b0;
    forever #20 i_f_ref = ~i_f_ref;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outs();
    return {o_scl, o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final,
            o_rx_done, o_start_det, o_stop_det, o_violation};
  endfunction

  task automatic run_to_high(input logic v, output int cyc);
    i_sda = v; i_start_rx = 1'b1;
    @(negedge i_clk);
    i_start_rx = 1'b0; scl_m = 1'b1; cyc = 0;
    while (o_scl !== 1'b1 && cyc < 60) begin cyc++; @(negedge i_clk); end
    total++;
    if (o_scl !== 1'b1) $display("FAIL scl_release_timeout got o_scl=%b want 1", o_scl);
    else passed++;
    @(negedge i_clk);
  endtask

  task automatic do_reset_check(input string name);
    i_rstn = 1'b0;
    @(negedge i_clk);
    total++;
    if (outs() !== RST_VEC) $display("FAIL %s got %b want %b", name, outs(), RST_VEC);
    else passed++;
    i_rstn = 1'b1; scl_m = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; scl_m = 1'b0; i_sda = 1'b1; i_start_rx = 1'b0; i_release_scl = 1'b1;
    repeat (2) @(negedge i_clk);
    total++;
    if (outs() !== RST_VEC) $display("FAIL reset_vals got %b want %b", outs(), RST_VEC);
    else passed++;
    i_rstn = 1'b1;
    @(negedge i_clk);
    total++;
    if (outs() !== RST_VEC) $display("FAIL idle_after_reset got %b want %b", outs(), RST_VEC);
    else passed++;
  endtask

  task automatic test_data_bit();
    int cyc;
    run_to_high(1'b1, cyc);
    total++;
    if (cyc < 13 || cyc > 20) $display("FAIL data_low_time got %0d want 13..20", cyc);
    else passed++;
    total++;
    if ({o_scl, o_sda_init_valid, o_sda_init} !== 3'b111)
      $display("FAIL data_init got %b want 111", {o_scl, o_sda_init_valid, o_sda_init});
    else passed++;
    repeat (20) @(negedge i_clk);
    total++;
    if ({o_sda_mid_change, o_rx_done} !== 2'b00)
      $display("FAIL data_high got %b want 00", {o_sda_mid_change, o_rx_done});
    else passed++;
    scl_m = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_final, o_sda_mid_change, o_rx_done} !== 3'b101)
      $display("FAIL data_done got %b want 101", {o_sda_final, o_sda_mid_change, o_rx_done});
    else passed++;
  endtask

  task automatic test_stretch();
    int rose = 0;
    i_release_scl = 1'b0; i_sda = 1'b0; i_start_rx = 1'b1;
    @(negedge i_clk);
    i_start_rx = 1'b0; scl_m = 1'b1;
    repeat (100) begin @(negedge i_clk); if (o_scl !== 1'b0) rose++; end
    total++;
    if (rose != 0) $display("FAIL stretch_hold got %0d released cycles want 0", rose);
    else passed++;
    total++;
    if ({o_scl, o_sda_init_valid, o_sda_init} !== 3'b010)
      $display("FAIL stretch_init got %b want 010", {o_scl, o_sda_init_valid, o_sda_init});
    else passed++;
    i_release_scl = 1'b1;
    @(negedge i_clk);
    total++;
    if (o_scl !== 1'b1) $display("FAIL stretch_release got %b want 1", o_scl);
    else passed++;
    repeat (6) @(negedge i_clk);
    scl_m = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_final, o_rx_done} !== 2'b01)
      $display("FAIL stretch_done got %b want 01", {o_sda_final, o_rx_done});
    else passed++;
  endtask

  task automatic test_rep_start();
    int cyc;
    run_to_high(1'b1, cyc);
    repeat (3) @(negedge i_clk);
    i_sda = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_start_det, o_stop_det, o_sda_mid_change} !== 3'b101)
      $display("FAIL rstart_det got %b want 101", {o_start_det, o_stop_det, o_sda_mid_change});
    else passed++;
    @(negedge i_clk);
    total++;
    if ({o_start_det, o_stop_det, o_sda_mid_change} !== 3'b001)
      $display("FAIL rstart_pulse got %b want 001", {o_start_det, o_stop_det, o_sda_mid_change});
    else passed++;
    repeat (3) @(negedge i_clk);
    scl_m = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_final, o_sda_mid_change, o_rx_done} !== 3'b011)
      $display("FAIL rstart_done got %b want 011", {o_sda_final, o_sda_mid_change, o_rx_done});
    else passed++;
  endtask

  task automatic test_stop();
    int cyc;
    run_to_high(1'b0, cyc);
    total++;
    if ({o_sda_init_valid, o_sda_init} !== 2'b10)
      $display("FAIL stop_init got %b want 10", {o_sda_init_valid, o_sda_init});
    else passed++;
    repeat (3) @(negedge i_clk);
    i_sda = 1'b1;
    @(negedge i_clk);
    total++;
    if ({o_start_det, o_stop_det, o_sda_mid_change, o_rx_done} !== 4'b0110)
      $display("FAIL stop_det got %b want 0110",
               {o_start_det, o_stop_det, o_sda_mid_change, o_rx_done});
    else passed++;
    cyc = 0;
    while (o_rx_done !== 1'b1 && cyc < 60) begin cyc++; @(negedge i_clk); end
    total++;
    if (o_rx_done !== 1'b1 || cyc < 10 || cyc > 20)
      $display("FAIL stop_free_time got done=%b after %0d want 1 in 10..20", o_rx_done, cyc);
    else passed++;
    total++;
    if ({o_sda_final, o_scl} !== 2'b11)
      $display("FAIL stop_final got %b want 11", {o_sda_final, o_scl});
    else passed++;
  endtask

  task automatic test_bus_free_start();
    i_start_rx = 1'b1;
    @(negedge i_clk);
    i_start_rx = 1'b0;
    total++;
    if ({o_scl, o_sda_init_valid, o_sda_init, o_rx_done, o_sda_mid_change} !== 5'b11100)
      $display("FAIL bfree_init got %b want 11100",
               {o_scl, o_sda_init_valid, o_sda_init, o_rx_done, o_sda_mid_change});
    else passed++;
    repeat (2) @(negedge i_clk);
    i_sda = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_start_det, o_sda_mid_change} !== 2'b11)
      $display("FAIL bfree_start got %b want 11", {o_start_det, o_sda_mid_change});
    else passed++;
    repeat (2) @(negedge i_clk);
    scl_m = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_final, o_rx_done} !== 2'b01)
      $display("FAIL bfree_done got %b want 01", {o_sda_final, o_rx_done});
    else passed++;
  endtask

  task automatic test_hold_edge();
    int cyc;
    run_to_high(1'b1, cyc);
    repeat (3) @(negedge i_clk);
    scl_m = 1'b0; i_sda = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_final, o_sda_mid_change, o_start_det, o_rx_done} !== 4'b1001)
      $display("FAIL hold_edge got %b want 1001",
               {o_sda_final, o_sda_mid_change, o_start_det, o_rx_done});
    else passed++;
  endtask

  task automatic test_viol_rel();
    int cyc = 0;
    i_start_rx = 1'b1;
    @(negedge i_clk);
    i_start_rx = 1'b0;
    while (o_scl !== 1'b1 && cyc < 60) begin cyc++; @(negedge i_clk); end
    total++;
    if (o_scl !== 1'b1) $display("FAIL rel_timeout got o_scl=%b want 1", o_scl);
    else passed++;
    i_sda = 1'b1;
    @(negedge i_clk);
    total++;
    if ({o_violation, o_rx_done, o_scl} !== 3'b101)
      $display("FAIL viol_rel got %b want 101", {o_violation, o_rx_done, o_scl});
    else passed++;
    i_start_rx = 1'b1;
    repeat (5) @(negedge i_clk);
    i_start_rx = 1'b0;
    total++;
    if ({o_violation, o_rx_done} !== 2'b10)
      $display("FAIL viol_sticky got %b want 10", {o_violation, o_rx_done});
    else passed++;
    do_reset_check("viol_rel_reset");
  endtask

  task automatic test_double_toggle();
    int cyc;
    run_to_high(1'b1, cyc);
    repeat (2) @(negedge i_clk);
    i_sda = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_sda_mid_change, o_violation} !== 2'b10)
      $display("FAIL dtog_first got %b want 10", {o_sda_mid_change, o_violation});
    else passed++;
    i_sda = 1'b1;
    @(negedge i_clk);
    total++;
    if ({o_violation, o_scl, o_rx_done} !== 3'b110)
      $display("FAIL dtog_viol got %b want 110", {o_violation, o_scl, o_rx_done});
    else passed++;
    do_reset_check("dtog_reset");
  endtask

  initial begin
    test_reset();
    test_data_bit();
    test_stretch();
    test_rep_start();
    test_stop();
    test_bus_free_start();
    test_hold_edge();
    test_viol_rel();
    test_double_toggle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_bitrx.md
Name: i2c_passthru_bitrx

Overview:
- Receive-side companion of the passthru bit transmitter. Observes one I2C bus segment (already synchronized and glitch-filtered) and decomposes each SCL period into the bit descriptor consumed by the far-side transmitter: init value, init-valid, mid-high SDA change, final value, done.
- Stretches SCL low on its own segment until the far side has released its SCL, so both segments stay bit-locked.
- Flags protocol violations (illegal SDA changes) to the passthru top-level.

Parameters:
- F_REF_T_SU_DAT, 2, i_f_ref rising edges SDA must be stable while SCL low before init is valid
- F_REF_T_LOW, 38, i_f_ref rising edges SCL must be low before init is valid; also the stop/bus-free hold time
- WIDTH_F_REF_T_SU_DAT, 2, ceil(log2(F_REF_T_SU_DAT+1))
- WIDTH_F_REF_T_LOW, 6, ceil(log2(F_REF_T_LOW+1))

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  synchronous active-low reset
- i_f_ref  input  1  periodic timing reference; rising edges counted
- i_start_rx  input  1  level/pulse; arms reception of one bit, sampled only in ST_IDLE
- i_release_scl  input  1  far side SCL is high; permits releasing local SCL
- i_scl  input  1  local SCL pad-in, synchronized
- i_sda  input  1  local SDA pad-in, synchronized
- o_scl  output  1  local SCL drive (0 = hold low, 1 = release)
- o_sda_init_valid  output  1  o_sda_init is usable by the far side
- o_sda_init  output  1  SDA value for the start of the SCL-high phase
- o_sda_mid_change  output  1  SDA toggled once while SCL high (START/STOP)
- o_sda_final  output  1  SDA value at end of the bit
- o_rx_done  output  1  bit complete; descriptor stable
- o_start_det  output  1  one-cycle pulse: SDA 1->0 while SCL high
- o_stop_det  output  1  one-cycle pulse: SDA 0->1 while SCL high
- o_violation  output  1  sticky illegal-activity flag

Behaviour:
- Reset values: state ST_IDLE, o_scl=1, o_sda_init_valid=0, o_sda_init=1, o_sda_mid_change=0, o_sda_final=1, o_rx_done=1, o_start_det=0, o_stop_det=0, o_violation=0; both timers loaded to their parameter value.
- pulse_ref = i_f_ref & ~prev_f_ref. Timers decrement on pulse_ref and saturate at 0 (terminal count).
  - t_low timer: reloads while i_scl=1 or in ST_IDLE.
  - t_su timer: reloads on any i_sda change.
- ST_IDLE: o_rx_done=1, descriptor outputs held. On i_start_rx:
  - i_scl=0: clear mid_change, init_valid, rx_done; go ST_SCL0_HOLD.
  - i_scl=1 (bus free, START pending): latch o_sda_init=i_sda, init_valid=1, clear mid_change and rx_done; go ST_SCL1.
- ST_SCL0_HOLD: o_scl=0.
  - o_sda_init follows i_sda.
  - o_sda_init_valid = t_low tc & t_su tc, combinational in this state. An SDA change drops it the next cycle and restarts t_su. This is not a violation.
  - Go ST_SCL0_REL when o_sda_init_valid & i_release_scl.
- ST_SCL0_REL: o_scl=1, o_sda_init frozen, init_valid=1.
  - SDA change → ST_VIOLATION.
  - i_scl=1 → ST_SCL1.
- ST_SCL1: o_scl=1.
  - First SDA change: o_sda_mid_change=1 held; one-cycle o_start_det if new SDA=0, o_stop_det if new SDA=1.
  - Second SDA change while i_scl=1 → ST_VIOLATION.
  - i_scl falls: o_sda_final = SDA registered the cycle before the fall (prev_i_sda), which ignores hold-time SDA moves. o_rx_done=1; go ST_IDLE.
  - After a STOP (mid_change=1, SDA=1) with SCL high and SDA stable for F_REF_T_LOW ref edges: o_sda_final=1, o_rx_done=1, go ST_IDLE (bus free).
- ST_VIOLATION: o_violation=1, o_scl=1, o_rx_done=0; exits only via reset.
- Simultaneous SCL fall and SDA change in ST_SCL1: treated as a fall. final = prev SDA; no mid_change update.
- i_start_rx outside ST_IDLE is ignored.
- Reset mid-bit returns to reset values within one clock; SCL released immediately.
- Latency: descriptor outputs register one clock after the triggering pad edge.

Test Plan (F_REF_T_LOW=4, F_REF_T_SU_DAT=2, i_f_ref period 4 clks):
- Data bit: start_rx with SCL=0, SDA=1 stable; release_scl=1 → o_scl=0 for ≥4 ref edges, init_valid=1/init=1, o_scl=1. SCL high 20 clks, then low → final=1, mid_change=0, rx_done=1.
- Stretch: SDA set 0, release_scl held 0 for 100 clks → o_scl stays 0, init_valid=1, init=0. Release → o_scl=1 the next clock.
- Repeated START: init=1, SDA 1→0 during SCL high → start_det pulse, mid_change=1, then SCL falls → final=0, rx_done=1.
- STOP: init=0, SDA 0→1 with SCL high, held 4 ref edges → stop_det pulse, final=1, rx_done=1 without an SCL fall.
- Violations:
  - SDA changes in ST_SCL0_REL → o_violation=1 sticky.
  - Two SDA toggles in one SCL high → o_violation=1.
  - Reset clears o_violation; outputs return to reset values.
- Hold-time edge: SDA changes on the same clock SCL falls → final equals the pre-fall SDA, mid_change=0.
